// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning logic.
//  - btn_state_e           : 2-bit debounce FSM state encoding
//  - STABLE_CYCLES_DEFAULT : default stability window (10 ms at 100 MHz)
// No ports; imported by btn_debounce_pulse.
// -----------------------------------------------------------------------------
package btn_pkg;

  // Debounce FSM states: two settled levels plus a qualifying state for each
  // direction of change.
  typedef enum logic [1:0] {
    S_ZERO  = 2'd0,
    S_WAIT1 = 2'd1,
    S_ONE   = 2'd2,
    S_WAIT0 = 2'd3
  } btn_state_e;

  // Consecutive synchronised-stable cycles needed before a new level is accepted.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous pad input.
// Ports:
//  clk   in  1  destination clock
//  reset in  1  asynchronous active-low reset, clears both flops
//  d     in  1  asynchronous input
//  q     out 1  synchronised output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; only the second flop is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
// Conditions a raw, bouncy push-button for the LED toggle stage: synchronises
// the pin, requires STABLE_CYCLES consecutive stable samples before accepting a
// new level, and emits single-cycle press/release pulses.
// Parameters:
//  STABLE_CYCLES  stability window in clk cycles (>= 1)
// Ports:
//  clk            in  1  system clock
//  reset          in  1  asynchronous active-low reset
//  btn_raw        in  1  raw pad input, asynchronous to clk
//  db_level       out 1  debounced level (registered)
//  press_pulse    out 1  one-cycle pulse on accepted 0->1 (registered)
//  release_pulse  out 1  one-cycle pulse on accepted 1->0 (registered)
// -----------------------------------------------------------------------------
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_sync;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_done;
  logic             db_level_q;
  logic             press_q;
  logic             release_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  // The counter only advances while below CNT_LAST, so it never wraps.
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign cnt_done = (cnt_q == CNT_LAST);

  // Debounce FSM. The entry edge of a WAIT state is itself the first stable
  // sample, and the last sample is checked on the cnt_done edge, so a bounce
  // arriving right at the end still aborts the change.
  // db_level is updated together with the state so it is high exactly in
  // S_ONE and S_WAIT0, and rises in the same cycle as press_pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        S_ZERO: begin
          if (btn_sync) begin
            state_q <= S_WAIT1;
            cnt_q   <= '0;
          end
        end
        S_WAIT1: begin
          if (!btn_sync) begin
            state_q <= S_ZERO;
          end else if (cnt_done) begin
            state_q    <= S_ONE;
            db_level_q <= 1'b1;
            press_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ONE: begin
          if (!btn_sync) begin
            state_q <= S_WAIT0;
            cnt_q   <= '0;
          end
        end
        S_WAIT0: begin
          if (btn_sync) begin
            state_q <= S_ONE;
          end else if (cnt_done) begin
            state_q    <= S_ZERO;
            db_level_q <= 1'b0;
            release_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q    <= S_ZERO;
          cnt_q      <= '0;
          db_level_q <= 1'b0;
        end
      endcase
    end
  end

  assign db_level      = db_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule : btn_debounce_pulse

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
// Self-checking bench for btn_debounce_pulse with STABLE_CYCLES=4. A
// behavioural model (raw-sample delay line plus a window of the most recent
// synchronised samples) predicts the outputs every cycle; directed scenarios
// also pin both the DUT and the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  localparam int STABLE = 4;

  logic clk;
  logic reset;
  logic btn_raw;
  logic db_level;
  logic press_pulse;
  logic release_pulse;

  int totalCount = 0;
  int badCount   = 0;

  // Model state: expected outputs after the most recent rising edge.
  logic mDb    = 1'b0;
  logic mPress = 1'b0;
  logic mRel   = 1'b0;
  bit   rawDelayQ[$];
  bit   windowQ[$];

  btn_debounce_pulse #(
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .db_level      (db_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, actual, expected);
    end
  endtask

  // Drive new input values on the falling edge so the following rising edge
  // (edge 0 of the new stimulus) sees them cleanly.
  task automatic applyStimulus(input logic rawVal, input logic rstVal);
    @(negedge clk);
    btn_raw = rawVal;
    reset   = rstVal;
  endtask

  // Advance one edge and pin both DUT and model to literal expectations.
  task automatic stepAndCheck(input string name, input logic expDb, input logic expPress,
                              input logic expRel);
    @(posedge clk);
    #2;
    checkOutput({name, " db"},          db_level,      expDb);
    checkOutput({name, " press"},       press_pulse,   expPress);
    checkOutput({name, " release"},     release_pulse, expRel);
    checkOutput({name, " model db"},    mDb,           expDb);
    checkOutput({name, " model press"}, mPress,        expPress);
    checkOutput({name, " model rel"},   mRel,          expRel);
  endtask

  // Step nSteps edges; a press/release is expected at the given step index
  // (-1 for none), with db_level following from dbStart.
  task automatic expectWindow(input string name, input int nSteps, input logic dbStart,
                              input int pressStep, input int relStep);
    logic db;
    db = dbStart;
    for (int i = 0; i < nSteps; i++) begin
      if (i == pressStep) db = 1'b1;
      if (i == relStep)   db = 1'b0;
      stepAndCheck($sformatf("%s e%0d", name, i), db, i == pressStep, i == relStep);
    end
  endtask

  // Check outputs right now, between edges (asynchronous reset effect).
  task automatic checkNow(input string name, input logic expDb);
    #1;
    checkOutput({name, " db"},      db_level,      expDb);
    checkOutput({name, " press"},   press_pulse,   1'b0);
    checkOutput({name, " release"}, release_pulse, 1'b0);
  endtask

  // Reference model plus per-cycle compare. On each rising edge the raw input
  // enters a two-deep delay line (the synchroniser); the sample leaving it is
  // the value the debouncer judges on that edge. A new level is accepted when
  // the last STABLE+1 judged samples all differ from the current level, and
  // the window restarts after each acceptance or reset.
  always @(posedge clk) begin
    logic rawS;
    logic rstS;
    bit   judged;
    bit   allDiffer;
    rawS = btn_raw;
    rstS = reset;
    #1;
    mPress = 1'b0;
    mRel   = 1'b0;
    if (!rstS) begin
      mDb = 1'b0;
      rawDelayQ = '{1'b0, 1'b0};
      windowQ.delete();
    end else begin
      if (rawDelayQ.size() != 2) rawDelayQ = '{1'b0, 1'b0};
      judged = rawDelayQ.pop_front();
      rawDelayQ.push_back(rawS);
      windowQ.push_back(judged);
      if (windowQ.size() > STABLE + 1) void'(windowQ.pop_front());
      if (windowQ.size() == STABLE + 1) begin
        allDiffer = 1'b1;
        foreach (windowQ[k]) if (windowQ[k] == mDb) allDiffer = 1'b0;
        if (allDiffer) begin
          mDb = ~mDb;
          if (mDb) mPress = 1'b1;
          else     mRel   = 1'b1;
          windowQ.delete();
        end
      end
    end
    checkOutput("cmp db",      db_level,      mDb);
    checkOutput("cmp press",   press_pulse,   mPress);
    checkOutput("cmp release", release_pulse, mRel);
    if (press_pulse && release_pulse) checkOutput("cmp both pulses", 1'b1, 1'b0);
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    int hold;
    btn_raw = 1'b0;
    reset   = 1'b0;

    // Reset held with the button pressed: everything stays low.
    applyStimulus(1'b1, 1'b0);
    expectWindow("rst hold", 5, 1'b0, -1, -1);
    // Release reset: press after edge 6.
    applyStimulus(1'b1, 1'b1);
    expectWindow("rst release", 10, 1'b0, 6, -1);

    // Release from db_level=1.
    applyStimulus(1'b0, 1'b1);
    expectWindow("release", 10, 1'b1, -1, 6);

    // Clean press held 20 cycles, then release.
    applyStimulus(1'b1, 1'b1);
    expectWindow("clean press", 20, 1'b0, 6, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("clean rel", 10, 1'b1, -1, 6);

    // Bounce 1,0,1,0 then steady 1: press 6 edges after the final 1.
    applyStimulus(1'b1, 1'b1); stepAndCheck("bounce e0", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1); stepAndCheck("bounce e1", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1); stepAndCheck("bounce e2", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1); stepAndCheck("bounce e3", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectWindow("bounce tail", 12, 1'b0, 6, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("bounce rel", 10, 1'b1, -1, 6);

    // Glitch of 3 cycles: suppressed.
    applyStimulus(1'b1, 1'b1);
    expectWindow("glitch3 hi", 3, 1'b0, -1, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("glitch3 lo", 12, 1'b0, -1, -1);

    // 4-cycle pulse: the drop lands on the cnt==STABLE-1 edge, so it aborts.
    applyStimulus(1'b1, 1'b1);
    expectWindow("glitch4 hi", 4, 1'b0, -1, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("glitch4 lo", 12, 1'b0, -1, -1);

    // 5-cycle pulse: just long enough; press at edge 6, release at edge 11.
    applyStimulus(1'b1, 1'b1);
    expectWindow("pulse5 hi", 5, 1'b0, -1, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("pulse5 lo", 12, 1'b0, 1, 6);

    // Reset mid-count (S_WAIT1, cnt=2 after edge 4), then a fresh full count.
    applyStimulus(1'b1, 1'b1);
    expectWindow("midcnt pre", 5, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b0);
    checkNow("midcnt async", 1'b0);
    expectWindow("midcnt hold", 3, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b1);
    expectWindow("midcnt fresh", 10, 1'b0, 6, -1);

    // Reset while db_level=1 must clear it without waiting for an edge.
    applyStimulus(1'b1, 1'b0);
    checkNow("db1 async", 1'b0);
    expectWindow("db1 hold", 2, 1'b0, -1, -1);
    applyStimulus(1'b0, 1'b1);
    expectWindow("db1 after", 8, 1'b0, -1, -1);

    // Randomized soak: mix of short bounces, long holds and occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 4);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1);
      repeat (hold) @(posedge clk);
    end
    applyStimulus(1'b0, 1'b1);
    repeat (12) @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule : tb_btn_debounce_pulse
